// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: FSM state encoding and output widths.
package count_seq_pkg;

  localparam int COUNT_W = 8;
  localparam int LAPS_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter: advances on en, wraps MOD-1 -> 0, flags the wrapping step.
module mod_counter
  import count_seq_pkg::*;
#(
  parameter int MOD = 20
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  output logic [COUNT_W-1:0] count,
  output logic               wrap
);

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(MOD - 1);

  // wrap is combinational so the parent can update laps on the same edge as count.
  assign wrap = en && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Start/pause/clear sequencer: prescaled tick drives a modulo counter, laps counted to DONE.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int MOD  = 20,
  parameter int DIV  = 50_000_000,
  parameter int LAPS = 4
) (
  input  logic               CLOCK_50,
  input  logic               KEY0,
  input  logic               start,
  input  logic               pause,
  input  logic               clear,
  output logic [COUNT_W-1:0] count,
  output logic               rollover,
  output logic [LAPS_W-1:0]  laps,
  output logic [1:0]         state,
  output logic               done
);

  localparam int              PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
  localparam logic [LAPS_W-1:0] LAPS_LAST = LAPS_W'(LAPS - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc;
  logic          tick_q;
  logic          start_acc, run_step, tick, cnt_en, cnt_clr, wrap;

  // clear > pause > start: a start only counts when neither stronger input is present.
  assign start_acc = start && !pause && !clear;
  assign run_step  = (state_q == RUN) && !clear && !pause;
  assign tick      = run_step && (presc == PRESC_LAST);
  // The tick is registered once; a pause or clear drops the tick in flight.
  assign cnt_en    = tick_q && run_step;
  assign cnt_clr   = !KEY0 || clear || (state_q == IDLE) || (state_q == DONE);

  mod_counter #(.MOD(MOD)) u_mod_counter (
    .clk   (CLOCK_50),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count),
    .wrap  (wrap)
  );

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, PAUSED, DONE: if (start_acc) state_d = RUN;
        RUN: begin
          if (pause)                          state_d = PAUSED;
          else if (wrap && laps == LAPS_LAST) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      state_q <= IDLE;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick;
    end
  end

  // The cycle carrying pause still advances the prescaler; PAUSED then holds that value.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0 || clear) begin
      presc <= '0;
    end else if (state_q == RUN) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end else if (state_q != PAUSED) begin
      presc <= '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0 || clear) begin
      laps     <= '0;
      rollover <= 1'b0;
    end else begin
      rollover <= wrap;
      if (state_q == DONE && start_acc) begin
        laps <= '0;
      end else if (wrap) begin
        laps <= laps + 1'b1;
      end
    end
  end

  assign state = state_q;
  assign done  = (state_q == DONE);

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter MOD, default 20, counter modulus; legal range 2..256.
REQ-002 Parameter DIV, default 50_000_000, CLOCK_50 cycles per count tick; legal range 1..2^26.
REQ-003 Parameter LAPS, default 4, rollovers before DONE; legal range 1..15.
REQ-004 CLOCK_50  in  1  single clock; all state updates on its rising edge.
REQ-005 KEY0  in  1  reset, synchronous, active-low, sampled on the CLOCK_50 rising edge.
REQ-006 start  in  1  single-cycle pulse; start or resume the sequence.
REQ-007 pause  in  1  single-cycle pulse; freeze the sequence.
REQ-008 clear  in  1  single-cycle pulse; abort to IDLE.
REQ-009 count  out  8  current count value, 0..MOD-1, registered.
REQ-010 rollover  out  1  one-cycle pulse, registered, on each wrap from MOD-1 to 0.
REQ-011 laps  out  4  completed rollovers since the last start from IDLE or DONE.
REQ-012 state  out  2  current FSM state encoding.
REQ-013 done  out  1  high while in DONE.

Function
REQ-014 FSM states SHALL be IDLE=0, RUN=1, PAUSED=2, DONE=3.
REQ-015 Input priority SHALL be clear > pause > start in any cycle where more than one is asserted.
REQ-016 clear in any state: next state IDLE; count, laps and prescaler go to 0; rollover is 0.
REQ-017 IDLE: count, laps and prescaler held at 0; start leads to RUN on the next cycle; pause is ignored.
REQ-018 RUN: prescaler increments once per cycle; when prescaler==DIV-1, a tick occurs and the prescaler returns to 0.
REQ-019 Tick latency: count first reads 1 exactly DIV+1 cycles after the cycle in which state first reads RUN (DIV=1 gives count 1 two cycles after RUN).
REQ-020 On a tick with count<MOD-1: count increments by 1 and rollover is 0.
REQ-021 On a tick with count==MOD-1, the following SHALL all happen in the next cycle:
  - count goes to 0;
  - rollover pulses high for one cycle;
  - laps increments by 1.
REQ-022 If that wrap makes laps equal LAPS, the next state is DONE; otherwise the state stays RUN.
REQ-023 pause in RUN: next state PAUSED; the tick due in that cycle (if any) is suppressed; the prescaler value is retained.
REQ-024 PAUSED: count, laps and prescaler frozen; start leads to RUN and the prescaler continues from its retained value.
REQ-025 DONE: count stays 0 and laps stays LAPS; done is 1; pause is ignored.
REQ-026 start in DONE: next state RUN with laps, count and prescaler cleared to 0.
REQ-027 start while in RUN is ignored.
REQ-028 Prescaler width SHALL be ceil(log2(DIV)), minimum 1 bit; no arithmetic overflow is permitted at legal parameters.
REQ-029 done SHALL equal (state==DONE), decoded from the state register.

Reset
REQ-030 While KEY0==0 at a CLOCK_50 edge, all of the following take effect on that edge regardless of other inputs:
  - state goes to IDLE;
  - count, laps, prescaler, rollover and done go to 0.
REQ-031 Reset asserted mid-RUN or mid-PAUSED SHALL discard all progress; no rollover pulse is generated by the reset.
REQ-032 The first start accepted after KEY0 returns high SHALL behave exactly as a start from IDLE.

Structure
REQ-033 A shared package count_seq_pkg SHALL hold the following; the module SHALL import it:
  - state encodings IDLE, RUN, PAUSED, DONE;
  - the width constants for count (8) and laps (4).
REQ-034 The datapath SHALL be a sub-module mod_counter, containing:
  - ports: clock, synchronous clear, enable, count, wrap;
  - parameter MOD.
REQ-035 count_sequencer SHALL contain the FSM, the prescaler and the laps counter, and drive mod_counter's enable with the tick.

Verification
REQ-036 Reset: hold KEY0=0 for 3 cycles with start=1 -> state=0, count=0, laps=0, rollover=0, done=0.
REQ-037 Wrap, DIV=1, MOD=20: start pulse -> count runs 1..19 on consecutive cycles, then 0 with rollover=1 for one cycle, laps=1.
REQ-038 Pause, DIV=3: pause when count=7 and prescaler=1; idle 10 cycles -> count stays 7; then start -> count=8 two cycles after state reads RUN.
REQ-039 Completion, DIV=1, MOD=20, LAPS=2: start -> after 40 ticks state=3, done=1, count=0, laps=2; then start -> state=1, laps=0.
REQ-040 Priority: in PAUSED, assert clear, pause and start in the same cycle -> next cycle state=0, count=0, laps=0.
REQ-041 Reset mid-run: KEY0=0 at count=12, laps=1 -> next cycle all outputs 0; no rollover pulse.
